// File: rtl/smart_timer_if.sv
// -----------------------------------------------------------------------------
// smart_timer_if
// Control/status bundle for smart_timer. The master side (controller) issues
// start/length/freeze; the slave side (timer) returns done/flicker/remaining
// and busy. Clock and reset stay plain ports on the timer.
// -----------------------------------------------------------------------------
interface smart_timer_if;
  logic       t_start;
  logic [4:0] t_length;
  logic       t_freeze;
  logic       t_done;
  logic       t_flicker;
  logic [4:0] t_remaining;
  logic       t_busy;

  modport master (
    output t_start, t_length, t_freeze,
    input  t_done, t_flicker, t_remaining, t_busy
  );

  modport slave (
    input  t_start, t_length, t_freeze,
    output t_done, t_flicker, t_remaining, t_busy
  );
endinterface : smart_timer_if

// File: rtl/smart_timer.sv
// -----------------------------------------------------------------------------
// smart_timer
// Tick-based countdown timer. A prescaler divides clk by TICK_DIV to form
// ticks; a 5-bit count is loaded from t_length on t_start and decremented once
// per tick. Expiry produces a one-cycle t_done pulse. Optional flicker pulses
// mark each tick that lands inside the final FLICKER_WINDOW ticks.
//
// Build option: define SMART_TIMER_FLICKER_EN to enable the flicker pulses;
// without it t_flicker is tied low and the window comparison is not built.
// -----------------------------------------------------------------------------
module smart_timer #(
  parameter int         TICK_DIV       = 10,
  parameter logic [4:0] FLICKER_WINDOW = 5'd3
) (
  input  logic          clk,
  input  logic          reset,
  smart_timer_if.slave  bus
);

  // A one-cycle tick still needs a 1-bit prescaler to keep the vector legal.
  localparam int                 PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FROZEN = 2'd2
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [4:0]       r_count,   w_count_nxt;
  logic [PRE_W-1:0] r_pre,     w_pre_nxt;
  logic             r_done,    w_done_nxt;
  logic             r_flicker, w_flicker_nxt;

  logic             w_advance;
  logic             w_wrap;
  logic [4:0]       w_count_dec;
  logic             w_flicker_hit;

  assign w_count_dec = r_count - 5'd1;
  assign w_wrap      = (r_pre == PRE_LAST);

`ifdef SMART_TIMER_FLICKER_EN
  // A tick is inside the window when the new count is 1..FLICKER_WINDOW.
  assign w_flicker_hit = (w_count_dec != 5'd0) && (w_count_dec <= FLICKER_WINDOW);
`else
  logic [4:0] w_unused_flicker_window;
  assign w_unused_flicker_window = FLICKER_WINDOW;
  assign w_flicker_hit           = 1'b0;
`endif

  // Next-state, next-count and pulse generation.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_pre_nxt     = r_pre;
    w_done_nxt    = 1'b0;
    w_flicker_nxt = 1'b0;
    w_advance     = 1'b0;

    if (bus.t_start) begin
      // Start wins over freeze and silently discards any run in progress.
      w_count_nxt = bus.t_length;
      w_pre_nxt   = '0;
      if (bus.t_length == 5'd0) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end else begin
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          // Freeze has no meaning without a run; nothing moves here.
        end
        S_RUN: begin
          if (bus.t_freeze) begin
            w_state_nxt = S_FROZEN;
          end else begin
            w_advance = 1'b1;
          end
        end
        S_FROZEN: begin
          // Leaving freeze resumes counting on the same edge, so every edge
          // that sampled freeze high delays expiry by exactly one cycle.
          if (!bus.t_freeze) begin
            w_state_nxt = S_RUN;
            w_advance   = 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase

      if (w_advance) begin
        if (w_wrap) begin
          w_pre_nxt   = '0;
          w_count_nxt = w_count_dec;
          if (r_count == 5'd1) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_flicker_nxt = w_flicker_hit;
          end
        end else begin
          w_pre_nxt = r_pre + PRE_W'(1);
        end
      end
    end
  end

  // State, counters and registered pulses; reset abandons any run silently.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= 5'd0;
      r_pre     <= '0;
      r_done    <= 1'b0;
      r_flicker <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_pre     <= w_pre_nxt;
      r_done    <= w_done_nxt;
      r_flicker <= w_flicker_nxt;
    end
  end

  assign bus.t_done      = r_done;
  assign bus.t_flicker   = r_flicker;
  assign bus.t_remaining = r_count;
  assign bus.t_busy      = (r_state != S_IDLE);

endmodule : smart_timer

// File: tb/tb_smart_timer.sv
// -----------------------------------------------------------------------------
// tb_smart_timer
// Directed bench for smart_timer with TICK_DIV=4, FLICKER_WINDOW=3. Expected
// flicker pulses are taken as zero when SMART_TIMER_FLICKER_EN is not defined.
// Observed outputs are packed as {busy, done, flicker, remaining[4:0]}.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_smart_timer;

`ifdef SMART_TIMER_FLICKER_EN
  localparam bit FLK = 1'b1;
`else
  localparam bit FLK = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  smart_timer_if bus ();

  smart_timer #(
    .TICK_DIV       (4),
    .FLICKER_WINDOW (5'd3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs();
    return {bus.t_busy, bus.t_done, bus.t_flicker, bus.t_remaining};
  endfunction

  function automatic logic [7:0] pk(bit busy, bit done, bit flk, int rem);
    return {busy, done, flk, 5'(rem)};
  endfunction

  task automatic drive(logic s, logic [4:0] l, logic f);
    bus.t_start  = s;
    bus.t_length = l;
    bus.t_freeze = f;
  endtask

  // Reset overrides a held start request.
  task automatic test_reset();
    logic [7:0] o;
    reset = 1'b1;
    drive(1'b1, 5'd7, 1'b1);
    for (int k = 0; k < 2; k++) begin
      step();
      o = obs();
      n_total++;
      if (o !== 8'h00) $display("FAIL reset k=%0d got %b want %b", k, o, 8'h00);
      else n_pass++;
    end
    drive(1'b0, 5'd0, 1'b0);
    step();
    reset = 1'b0;
    step();
    o = obs();
    n_total++;
    if (o !== 8'h00) $display("FAIL reset_release got %b want %b", o, 8'h00);
    else n_pass++;
  endtask

  // L=3: flicker after E+4 and E+8, done and busy fall after E+12.
  task automatic test_basic();
    logic [7:0] o, e;
    drive(1'b1, 5'd3, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0);
    o = obs();
    n_total++;
    if (o !== pk(1, 0, 0, 3)) $display("FAIL basic_load got %b want %b", o, pk(1, 0, 0, 3));
    else n_pass++;
    for (int k = 1; k <= 13; k++) begin
      step();
      if (k < 12) e = pk(1, 0, FLK && (k == 4 || k == 8), 3 - k / 4);
      else        e = pk(0, k == 12, 0, 0);
      o = obs();
      n_total++;
      if (o !== e) $display("FAIL basic k=%0d got %b want %b", k, o, e);
      else n_pass++;
    end
  endtask

  // L=2 with freeze on edges E+2..E+11: count held, done after E+18.
  task automatic test_freeze();
    logic [7:0] o, e;
    drive(1'b1, 5'd2, 1'b0);
    step();
    for (int k = 1; k <= 19; k++) begin
      drive(1'b0, 5'd0, (k >= 2 && k <= 11));
      step();
      if (k < 14)      e = pk(1, 0, 0, 2);
      else if (k < 18) e = pk(1, 0, FLK && k == 14, 1);
      else             e = pk(0, k == 18, 0, 0);
      o = obs();
      n_total++;
      if (o !== e) $display("FAIL freeze k=%0d got %b want %b", k, o, e);
      else n_pass++;
    end
    drive(1'b0, 5'd0, 1'b0);
  endtask

  // Freeze while idle changes nothing.
  task automatic test_idle_freeze();
    logic [7:0] o;
    drive(1'b0, 5'd9, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step();
      o = obs();
      n_total++;
      if (o !== 8'h00) $display("FAIL idle_freeze k=%0d got %b want %b", k, o, 8'h00);
      else n_pass++;
    end
    drive(1'b0, 5'd0, 1'b0);
  endtask

  // Start with freeze high on the same edge: the load still happens; freeze
  // held two more edges then released, done after S+6.
  task automatic test_priority();
    logic [7:0] o, e;
    drive(1'b1, 5'd1, 1'b1);
    step();
    o = obs();
    n_total++;
    if (o !== pk(1, 0, 0, 1)) $display("FAIL priority_load got %b want %b", o, pk(1, 0, 0, 1));
    else n_pass++;
    for (int k = 1; k <= 7; k++) begin
      drive(1'b0, 5'd0, (k <= 2));
      step();
      e = (k < 6) ? pk(1, 0, 0, 1) : pk(0, k == 6, 0, 0);
      o = obs();
      n_total++;
      if (o !== e) $display("FAIL priority k=%0d got %b want %b", k, o, e);
      else n_pass++;
    end
    drive(1'b0, 5'd0, 1'b0);
  endtask

  // L=5 restarted with L=1 at E+6: single done after E+10, no flicker.
  task automatic test_back_to_back();
    logic [7:0] o, e;
    drive(1'b1, 5'd5, 1'b0);
    step();
    for (int k = 1; k <= 11; k++) begin
      if (k == 6) drive(1'b1, 5'd1, 1'b0);
      else        drive(1'b0, 5'd0, 1'b0);
      step();
      if (k < 4)       e = pk(1, 0, 0, 5);
      else if (k < 6)  e = pk(1, 0, 0, 4);
      else if (k < 10) e = pk(1, 0, 0, 1);
      else             e = pk(0, k == 10, 0, 0);
      o = obs();
      n_total++;
      if (o !== e) $display("FAIL restart k=%0d got %b want %b", k, o, e);
      else n_pass++;
    end
    drive(1'b0, 5'd0, 1'b0);
  endtask

  // L=0: immediate done pulse, never busy.
  task automatic test_zero_length();
    logic [7:0] o;
    drive(1'b1, 5'd0, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0);
    o = obs();
    n_total++;
    if (o !== pk(0, 1, 0, 0)) $display("FAIL zero_done got %b want %b", o, pk(0, 1, 0, 0));
    else n_pass++;
    for (int k = 1; k <= 2; k++) begin
      step();
      o = obs();
      n_total++;
      if (o !== 8'h00) $display("FAIL zero_after k=%0d got %b want %b", k, o, 8'h00);
      else n_pass++;
    end
  endtask

  // L=4 with reset at E+5: outputs clear, no done ever follows.
  task automatic test_reset_midrun();
    logic [7:0] o, e;
    drive(1'b1, 5'd4, 1'b0);
    step();
    drive(1'b0, 5'd0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      reset = (k == 5);
      step();
      if (k < 4)       e = pk(1, 0, 0, 4);
      else if (k == 4) e = pk(1, 0, FLK, 3);
      else             e = 8'h00;
      o = obs();
      n_total++;
      if (o !== e) $display("FAIL reset_midrun k=%0d got %b want %b", k, o, e);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    drive(1'b0, 5'd0, 1'b0);
    test_reset();
    test_basic();
    test_freeze();
    test_idle_freeze();
    test_priority();
    test_back_to_back();
    test_zero_length();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_smart_timer
